// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Scan images are indexed row*N_COLS + col, so a single low bit's index is the key code.
package keypad_pkg;

  localparam int unsigned N_ROWS = 4;
  localparam int unsigned N_COLS = 4;
  localparam int unsigned N_KEYS = N_ROWS * N_COLS;

  typedef enum logic [1:0] {
    StIdle,
    StDebounce,
    StPressed,
    StRelease
  } state_e;

  typedef enum logic [1:0] {
    ResNone,
    ResSingle,
    ResMulti
  } scan_res_e;

  // Rows are active-low: count low bits to tell no key / one key / ghosting chord.
  function automatic scan_res_e classify_scan(input logic [N_KEYS-1:0] image);
    int unsigned lows;
    lows = 0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (!image[i]) lows++;
    end
    if (lows == 0) return ResNone;
    if (lows == 1) return ResSingle;
    return ResMulti;
  endfunction

  // Index of the (last) low bit; only meaningful for a ResSingle image.
  function automatic logic [3:0] scan_code(input logic [N_KEYS-1:0] image);
    logic [3:0] code;
    code = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (!image[i]) code = 4'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// Column driver: dwells SCAN_DIV cycles per column, strobes the last dwell cycle
// for row sampling and flags the end of a full 4-column scan.
module keypad_col_scan #(
  parameter int unsigned SCAN_DIV = 25000
) (
  input  logic       clock,
  input  logic       reset,
  output logic [1:0] col_idx,
  output logic [3:0] col_out,
  output logic       sample_strobe,
  output logic       scan_end
);

  localparam int unsigned DwellW = $clog2(SCAN_DIV + 1);

  logic [DwellW-1:0] dwell_q;
  logic [1:0]        col_q;

  assign sample_strobe = (dwell_q == DwellW'(SCAN_DIV - 1));
  assign scan_end      = sample_strobe && (col_q == 2'd3);
  assign col_idx       = col_q;
  assign col_out       = ~(4'b0001 << col_q);

  // Dwell counter wraps on the sample cycle and steps the column (3 wraps to 0).
  always_ff @(posedge clock) begin
    if (reset) begin
      dwell_q <= '0;
      col_q   <= '0;
    end else if (sample_strobe) begin
      dwell_q <= '0;
      col_q   <= col_q + 2'd1;
    end else begin
      dwell_q <= dwell_q + DwellW'(1);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with per-scan debounce of press and release.
// Optional auto-repeat while held: define KEYPAD_AUTO_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 25000,
  parameter int unsigned DEBOUNCE_SCANS = 20,
  parameter int unsigned REPEAT_SCANS   = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_param_check
    $error("keypad_scanner: parameter out of range");
  end

  localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_SCANS);

  logic [1:0]        col_idx;
  logic              sample_strobe;
  logic              scan_end;
  logic [3:0]        row_meta_q;
  logic [3:0]        row_sync_q;
  logic [N_KEYS-1:0] image_q;
  logic [N_KEYS-1:0] img_now;
  scan_res_e         scan_res;
  logic [3:0]        scan_key;
  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [CntW-1:0]   cnt_inc;
  logic [3:0]        cand_q;

  keypad_col_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_col_scan (
    .clock        (clock),
    .reset        (reset),
    .col_idx      (col_idx),
    .col_out      (col_out),
    .sample_strobe(sample_strobe),
    .scan_end     (scan_end)
  );

  // Two-flop synchronizer; idles high so a reset looks like "no key".
  always_ff @(posedge clock) begin
    if (reset) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= row_in;
      row_sync_q <= row_meta_q;
    end
  end

  // Current column's rows merged into the image so scan end sees column 3 too.
  always_comb begin
    img_now = image_q;
    for (int r = 0; r < N_ROWS; r++) begin
      img_now[r * N_COLS + int'(col_idx)] = row_sync_q[r];
    end
  end

  // Accumulate one column of the scan image per sample strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      image_q <= '1;
    end else if (sample_strobe) begin
      image_q <= img_now;
    end
  end

  assign scan_res = classify_scan(img_now);
  assign scan_key = scan_code(img_now);
  assign cnt_inc  = (cnt_q < CntMax) ? cnt_q + CntW'(1) : cnt_q;

`ifdef KEYPAD_AUTO_REPEAT_EN
  localparam int unsigned RptW = $clog2(REPEAT_SCANS + 1);
  logic [RptW-1:0] rpt_q;
  logic [RptW-1:0] rpt_inc;
  assign rpt_inc = rpt_q + RptW'(1);
`endif

  // Debounce FSM, stepped once per completed scan; outputs are registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      cand_q    <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_AUTO_REPEAT_EN
      rpt_q     <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (scan_end) begin
        unique case (state_q)
          StIdle: begin
            if (scan_res == ResSingle) begin
              cand_q <= scan_key;
              if (DEBOUNCE_SCANS <= 1) begin
                state_q   <= StPressed;
                key_code  <= scan_key;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                cnt_q     <= '0;
`ifdef KEYPAD_AUTO_REPEAT_EN
                rpt_q     <= '0;
`endif
              end else begin
                state_q <= StDebounce;
                cnt_q   <= CntW'(1);
              end
            end
          end
          StDebounce: begin
            if (scan_res == ResSingle && scan_key == cand_q) begin
              if (cnt_inc >= CntMax) begin
                state_q   <= StPressed;
                key_code  <= cand_q;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                cnt_q     <= '0;
`ifdef KEYPAD_AUTO_REPEAT_EN
                rpt_q     <= '0;
`endif
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end
          end
          StPressed: begin
            if (scan_res == ResNone) begin
              if (DEBOUNCE_SCANS <= 1) begin
                state_q  <= StIdle;
                key_held <= 1'b0;
                cnt_q    <= '0;
              end else begin
                state_q <= StRelease;
                cnt_q   <= CntW'(1);
              end
            end else begin
`ifdef KEYPAD_AUTO_REPEAT_EN
              if (32'(rpt_inc) >= REPEAT_SCANS) begin
                rpt_q     <= '0;
                key_valid <= 1'b1;
              end else begin
                rpt_q <= rpt_inc;
              end
`endif
            end
          end
          StRelease: begin
            if (scan_res == ResNone) begin
              if (cnt_inc >= CntMax) begin
                state_q  <= StIdle;
                key_held <= 1'b0;
                cnt_q    <= '0;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              // Bounce during release: still the same press, no new key_valid.
              state_q <= StPressed;
              cnt_q   <= '0;
`ifdef KEYPAD_AUTO_REPEAT_EN
              rpt_q   <= '0;
`endif
            end
          end
          default: begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad matrix model drives row_in from the
// set of held keys, and a per-scan reference model predicts pulses, code and held level.
// Honours KEYPAD_AUTO_REPEAT_EN when it is defined for the build.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB      = 3;
  localparam int unsigned RPT      = 5;
`ifdef KEYPAD_AUTO_REPEAT_EN
  localparam bit AutoRep = 1'b1;
`else
  localparam bit AutoRep = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = '0;

  int total = 0;
  int bad   = 0;

  // Reference model state (one step per full scan).
  bit m_held;
  int m_streak, m_cand, m_rel, m_rpt, m_code;

  // Cross-scan observation state.
  logic       prev_v   = 1'b0;
  logic [3:0] last_col = 4'b1110;

  always #5 clock = ~clock;

  keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEB),
    .REPEAT_SCANS  (RPT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  // Keypad matrix: a held key (bit row*4+col) pulls its row low while its column is driven.
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!col_out[c] && keys[r * 4 + c]) row_in[r] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One scan of the reference: debounce counts whole scans of an unchanged single key.
  task automatic model_scan(input logic [15:0] k, output int exp_pulse);
    int n, code;
    n = $countones(k);
    code = 0;
    for (int i = 0; i < 16; i++) if (k[i]) code = i;
    exp_pulse = 0;
    if (!m_held) begin
      if (n == 1 && (m_streak == 0 || code == m_cand)) begin
        if (m_streak == 0) m_cand = code;
        m_streak++;
      end else begin
        m_streak = 0;
      end
      if (m_streak == DEB) begin
        m_held = 1'b1; m_code = m_cand; exp_pulse = 1;
        m_streak = 0; m_rel = 0; m_rpt = 0;
      end
    end else if (n == 0) begin
      m_rel++;
      if (m_rel == DEB) begin
        m_held = 1'b0; m_rel = 0;
      end
    end else if (m_rel > 0) begin
      m_rel = 0; m_rpt = 0;
    end else if (AutoRep) begin
      m_rpt++;
      if (m_rpt == RPT) begin
        m_rpt = 0; exp_pulse = 1;
      end
    end
  endtask

  // Hold key set k for one full scan (starting at a scan boundary), then check outcome.
  task automatic do_scan(input logic [15:0] k, input string tag, output int pulses);
    int exp_pulse, consec;
    logic [3:0] seen_code;
    bit done;
    pulses = 0; consec = 0; seen_code = '0; done = 1'b0;
    keys = k;
    model_scan(k, exp_pulse);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clock);
      if (key_valid) begin
        pulses++;
        seen_code = key_code;
        if (prev_v) consec++;
      end
      prev_v = key_valid;
      if (col_out == 4'b1110 && last_col == 4'b0111) done = 1'b1;
      last_col = col_out;
    end
    check({tag, " scan_boundary"}, 32'(done), 32'd1);
    check({tag, " valid_pulses"}, 32'(pulses), 32'(exp_pulse));
    check({tag, " back_to_back_valid"}, 32'(consec), 32'd0);
    check({tag, " key_held"}, 32'(key_held), 32'(m_held));
    if (exp_pulse > 0) check({tag, " key_code"}, 32'(seen_code), 32'(m_code));
  endtask

  task automatic scans(input logic [15:0] k, input int n, input string tag, output int sum);
    int p;
    sum = 0;
    for (int i = 0; i < n; i++) begin
      do_scan(k, tag, p);
      sum += p;
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check({tag, " col_out"}, 32'(col_out), 32'h0000_000E);
    check({tag, " key_held"}, 32'(key_held), 32'd0);
    check({tag, " key_valid"}, 32'(key_valid), 32'd0);
    check({tag, " key_code"}, 32'(key_code), 32'd0);
    reset = 1'b0;
    m_held = 1'b0; m_streak = 0; m_cand = 0; m_rel = 0; m_rpt = 0; m_code = 0;
    prev_v = 1'b0;
    last_col = 4'b1110;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected test done");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int sum;
    logic [15:0] k9;
    k9 = 16'h0200;
    repeat (3) @(negedge clock);
    do_reset("power_on_reset");

    // Basic accept, then clean release.
    scans(k9, 3, "accept", sum);
    check("accept pulse_total", 32'(sum), 32'd1);
    scans('0, 3, "release", sum);

    // Too short a press.
    scans(k9, 2, "short_press", sum);
    scans('0, 4, "short_release", sum);
    check("short pulse_total", 32'(sum), 32'd0);

    // Two keys in row 0 (columns 0 and 1) is ambiguous.
    scans(16'h0003, 10, "multi", sum);
    check("multi pulse_total", 32'(sum), 32'd0);
    scans('0, 2, "multi_release", sum);

    // Release bounce returns to pressed without a second key_valid.
    scans(k9, 3, "bounce_accept", sum);
    scans('0, 2, "bounce_rel", sum);
    scans(k9, 1, "bounce_repress", sum);
    check("bounce no_second_valid", 32'(sum), 32'd0);
    scans('0, 3, "bounce_final_rel", sum);

    // Reset while pressed discards the press; still-held key is re-debounced.
    scans(k9, 4, "pre_reset", sum);
    do_reset("mid_press_reset");
    scans(k9, 3, "post_reset", sum);
    check("post_reset pulse_total", 32'(sum), 32'd1);
    scans('0, 3, "post_reset_rel", sum);

    // Long hold: auto-repeat pulses every RPT scans after acceptance when enabled.
    scans(k9, 13, "long_hold", sum);
    check("long_hold pulse_total", 32'(sum), AutoRep ? 32'd3 : 32'd1);
    scans('0, 3, "long_hold_rel", sum);

    // Random runs of no key, single keys and chords.
    for (int run = 0; run < 40; run++) begin
      logic [15:0] k;
      int kind, len, a, b;
      kind = int'($urandom_range(0, 3));
      len  = int'($urandom_range(1, 6));
      a    = int'($urandom_range(0, 15));
      b    = (a + int'($urandom_range(1, 15))) % 16;
      k = '0;
      if (kind == 1 || kind == 2) k[a] = 1'b1;
      if (kind == 3) begin
        k[a] = 1'b1;
        k[b] = 1'b1;
      end
      scans(k, len, "random", sum);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 25000, giving the clock cycles each column is driven (minimum 4).
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 20, giving the consecutive identical full scans needed to accept a press or a release.
REQ-003 SHALL have parameter REPEAT_SCANS, default 250, giving the auto-repeat interval in full scans; it is used only under KEYPAD_AUTO_REPEAT_EN.
REQ-004 clock  input  1  single clock for the whole block; all flops on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 row_in  input  4  keypad rows, active-low with external pull-ups, asynchronous to clock.
REQ-007 col_out  output  4  column drive, active-low one-hot.
REQ-008 key_code  output  4  accepted key, {row_idx[1:0], col_idx[1:0]}.
REQ-009 key_valid  output  1  one-cycle pulse per accepted press, or per repeat.
REQ-010 key_held  output  1  level, high from acceptance until release is accepted.

Function
REQ-011 row_in SHALL pass through a 2-flop synchronizer before any use.
REQ-012 Column scan: the dwell counter counts 0..SCAN_DIV-1; col_idx advances 0→1→2→3→0 on dwell wrap; col_out = ~(4'b0001 << col_idx).
REQ-013 The synchronized rows SHALL be sampled on the last dwell cycle of each column and accumulated into a 16-bit scan image.
REQ-014 When column 3 is sampled, a scan result SHALL be formed: NONE (0 bits low), SINGLE plus code (exactly 1 bit low), or MULTI (2 or more bits low).
REQ-015 FSM states: IDLE, DEBOUNCE, PRESSED, RELEASE. Transitions are evaluated only at scan end.
REQ-016 IDLE: SINGLE leads to DEBOUNCE with cand=code and cnt=1. NONE or MULTI keeps the FSM in IDLE.
REQ-017 DEBOUNCE: SINGLE with the same code increments cnt. When cnt reaches DEBOUNCE_SCANS, the FSM goes to PRESSED, latches key_code=cand, and pulses key_valid in the next cycle. Any other result returns the FSM to IDLE.
REQ-018 PRESSED: key_held=1. NONE leads to RELEASE with cnt=1. SINGLE (any code) or MULTI keeps the FSM in PRESSED; key_code is unchanged.
REQ-019 RELEASE: NONE increments cnt. When cnt reaches DEBOUNCE_SCANS, the FSM goes to IDLE and key_held drops in the same cycle as the transition. Any SINGLE or MULTI returns the FSM to PRESSED with no new key_valid.
REQ-020 key_valid SHALL never be high for 2 consecutive cycles; key_code SHALL be stable while key_valid is high.
REQ-021 Counters SHALL saturate and never wrap; widths SHALL be $clog2(param+1).

Reset
REQ-022 Reset SHALL set the following in the cycle after reset is sampled high, overriding all other activity:
- FSM state IDLE
- dwell, col_idx, cnt and repeat counters 0
- col_out=4'b1110
- key_code=0, key_valid=0, key_held=0
- synchronizer flops 4'b1111
- scan image cleared
REQ-023 Reset asserted mid-press SHALL discard the press; a key still held after reset SHALL be re-debounced from IDLE.

Configuration
REQ-024 With KEYPAD_AUTO_REPEAT_EN defined, PRESSED SHALL count completed scans. Every REPEAT_SCANS scans it SHALL re-pulse key_valid with the latched key_code. The repeat counter clears on entry to PRESSED, including re-entry from RELEASE.
REQ-025 Without KEYPAD_AUTO_REPEAT_EN, the repeat counter and its logic SHALL be absent, and exactly one key_valid SHALL be emitted per accepted press.

Structure
REQ-026 Package keypad_pkg SHALL hold the FSM state enum, the scan-result enum (NONE/SINGLE/MULTI), and N_ROWS=4 and N_COLS=4.
REQ-027 Sub-module keypad_col_scan SHALL hold the dwell counter, col_idx and col_out generation, and SHALL emit sample_strobe and scan_end.

Verification
All scenarios use SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_SCANS=5. Key 9 means row_in=4'b1011 while col_out=4'b1101, with row_in=4'b1111 otherwise.
REQ-028 Hold key 9 for 3 full scans: exactly one key_valid pulse with key_code=4'h9, and key_held=1.
REQ-029 Key 9 for 2 scans, then released: no key_valid, and key_held stays 0.
REQ-030 Row 0 low for columns 0 and 1 in the same scan (MULTI) for 10 scans: no key_valid.
REQ-031 After acceptance, release for 2 scans, press key 9 again, then release for 3 scans:
- no second key_valid
- key_held stays 1 until the 3rd release scan ends, then drops to 0.
REQ-032 Reset pulsed while in PRESSED: the next cycle shows col_out=4'b1110 and key_held=0. With key 9 still held, key_valid reappears 3 scans later.
REQ-033 Hold key 9 for 13 scans: 3 key_valid pulses (scans 3, 8 and 13) with KEYPAD_AUTO_REPEAT_EN defined; 1 pulse without it.
